// File: rtl/game_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : game_cmd_driver
//  Description : Takes valid/ready game commands, drives the game-state
//                counter's load/enable/control pins and returns one response
//                per command with winner/loser/cycle/game-over results.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_cmd_driver #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_init,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [1:0]       game_ctrl,
    output logic             game_en,
    output logic             game_init_load,
    output logic [WIDTH-1:0] game_init_val,
    input  logic             game_winner,
    input  logic             game_loser,
    input  logic             game_over,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] rsp_winners,
    output logic [CNT_W-1:0] rsp_losers,
    output logic [LEN_W-1:0] rsp_cycles,
    output logic             rsp_over,
    output logic             busy
);

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_LOAD  = 3'd1;
    localparam logic [2:0] C_RUN   = 3'd2;
    localparam logic [2:0] C_DRAIN = 3'd3;
    localparam logic [2:0] C_RESP  = 3'd4;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [2:0]       r_state_q,   w_state_d;
    logic [1:0]       r_op_q,      w_op_d;
    logic [WIDTH-1:0] r_init_q,    w_init_d;
    logic [LEN_W-1:0] r_rem_q,     w_rem_d;
    logic [LEN_W-1:0] r_cycles_q,  w_cycles_d;
    logic [CNT_W-1:0] r_winners_q, w_winners_d;
    logic [CNT_W-1:0] r_losers_q,  w_losers_d;
    logic             r_over_q,    w_over_d;
    logic             w_sample;

    // Flags from the game lag one cycle, so DRAIN also samples them
    assign w_sample = (r_state_q == C_RUN) || (r_state_q == C_DRAIN);

    always_comb begin
        w_state_d   = r_state_q;
        w_op_d      = r_op_q;
        w_init_d    = r_init_q;
        w_rem_d     = r_rem_q;
        w_cycles_d  = r_cycles_q;
        w_winners_d = r_winners_q;
        w_losers_d  = r_losers_q;
        w_over_d    = r_over_q;

        if (w_sample) begin
            if (game_winner && (r_winners_q != C_CNT_MAX)) begin
                w_winners_d = r_winners_q + CNT_W'(1);
            end
            if (game_loser && (r_losers_q != C_CNT_MAX)) begin
                w_losers_d = r_losers_q + CNT_W'(1);
            end
        end

        case (r_state_q)
            C_IDLE: begin
                if (cmd_valid) begin
                    w_op_d      = cmd_op;
                    w_init_d    = cmd_init;
                    w_rem_d     = cmd_len;
                    w_cycles_d  = '0;
                    w_winners_d = '0;
                    w_losers_d  = '0;
                    w_over_d    = 1'b0;
                    if (cmd_load) begin
                        w_state_d = C_LOAD;
                    end else if (cmd_len != '0) begin
                        w_state_d = C_RUN;
                    end else begin
                        w_state_d = C_DRAIN;
                    end
                end
            end
            C_LOAD: begin
                w_state_d = (r_rem_q != '0) ? C_RUN : C_DRAIN;
            end
            C_RUN: begin
                if (game_over) begin
                    w_over_d  = 1'b1;
                    w_state_d = C_RESP;
                end else begin
                    w_rem_d    = r_rem_q - LEN_W'(1);
                    w_cycles_d = r_cycles_q + LEN_W'(1);
                    if (r_rem_q == LEN_W'(1)) begin
                        w_state_d = C_DRAIN;
                    end
                end
            end
            C_DRAIN: begin
                if (game_over) begin
                    w_over_d = 1'b1;
                end
                w_state_d = C_RESP;
            end
            C_RESP: begin
                if (rsp_ready) begin
                    w_state_d = C_IDLE;
                end
            end
            default: begin
                w_state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= C_IDLE;
            r_op_q      <= '0;
            r_init_q    <= '0;
            r_rem_q     <= '0;
            r_cycles_q  <= '0;
            r_winners_q <= '0;
            r_losers_q  <= '0;
            r_over_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_op_q      <= w_op_d;
            r_init_q    <= w_init_d;
            r_rem_q     <= w_rem_d;
            r_cycles_q  <= w_cycles_d;
            r_winners_q <= w_winners_d;
            r_losers_q  <= w_losers_d;
            r_over_q    <= w_over_d;
        end
    end

    assign cmd_ready      = (r_state_q == C_IDLE);
    assign busy           = (r_state_q != C_IDLE);
    assign game_ctrl      = ((r_state_q == C_LOAD) || (r_state_q == C_RUN) ||
                             (r_state_q == C_DRAIN)) ? r_op_q : 2'b00;
    // Enable falls in the same cycle game_over is seen
    assign game_en        = (r_state_q == C_RUN) && !game_over;
    assign game_init_load = (r_state_q == C_LOAD);
    assign game_init_val  = (r_state_q == C_LOAD) ? r_init_q : '0;
    assign rsp_valid      = (r_state_q == C_RESP);
    assign rsp_winners    = r_winners_q;
    assign rsp_losers     = r_losers_q;
    assign rsp_cycles     = r_cycles_q;
    assign rsp_over       = r_over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_cmd_driver
//  Description : Directed and randomized bench for game_cmd_driver with a
//                cycle-timeline reference model of each command.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_cmd_driver;

    localparam int C_N = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_load;
    logic [3:0] cmd_init;
    logic [7:0] cmd_len;
    logic [1:0] game_ctrl;
    logic       game_en;
    logic       game_init_load;
    logic [3:0] game_init_val;
    logic       game_winner;
    logic       game_loser;
    logic       game_over;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_winners;
    logic [3:0] rsp_losers;
    logic [7:0] rsp_cycles;
    logic       rsp_over;
    logic       busy;

    int n_err    = 0;
    int n_checks = 0;

    // Flag stimulus indexed by cycle offset after the accepting edge
    bit fw [C_N];
    bit fl [C_N];
    bit fo [C_N];

    game_cmd_driver #(.WIDTH(4), .LEN_W(8), .CNT_W(4)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_load       (cmd_load),
        .cmd_init       (cmd_init),
        .cmd_len        (cmd_len),
        .game_ctrl      (game_ctrl),
        .game_en        (game_en),
        .game_init_load (game_init_load),
        .game_init_val  (game_init_val),
        .game_winner    (game_winner),
        .game_loser     (game_loser),
        .game_over      (game_over),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_winners    (rsp_winners),
        .rsp_losers     (rsp_losers),
        .rsp_cycles     (rsp_cycles),
        .rsp_over       (rsp_over),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_flags();
        for (int i = 0; i < C_N; i++) begin
            fw[i] = 1'b0;
            fl[i] = 1'b0;
            fo[i] = 1'b0;
        end
    endtask

    task automatic rnd_flags(input int pw, input int pl, input int po);
        for (int i = 0; i < C_N; i++) begin
            fw[i] = ($urandom_range(99) < pw);
            fl[i] = ($urandom_range(99) < pl);
            fo[i] = ($urandom_range(99) < po);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic ld, input logic [3:0] init,
                           input logic [7:0] len, input int bp, input bit hold_v);
        int  t, tend, ew, el, ec;
        bit  eo, stop;
        bit  en_exp [C_N];

        // Reference: walk the command timeline (optional load, run, drain)
        for (int i = 0; i < C_N; i++) en_exp[i] = 1'b0;
        t = ld ? 1 : 0;
        ew = 0; el = 0; ec = 0; eo = 1'b0; stop = 1'b0;
        for (int j = 0; j < int'(len) && !stop; j++) begin
            ew = (fw[t] && ew < 15) ? ew + 1 : ew;
            el = (fl[t] && el < 15) ? el + 1 : el;
            if (fo[t]) begin
                eo   = 1'b1;
                stop = 1'b1;
            end else begin
                en_exp[t] = 1'b1;
                ec++;
                t++;
            end
        end
        if (!stop) begin
            ew = (fw[t] && ew < 15) ? ew + 1 : ew;
            el = (fl[t] && el < 15) ? el + 1 : el;
            if (fo[t]) eo = 1'b1;
        end
        tend = t + 1;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_load  = ld;
        cmd_init  = init;
        cmd_len   = len;
        rsp_ready = 1'b0;
        #1;
        chk("accept_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        for (int i = 0; i <= tend; i++) begin
            @(negedge clk);
            if (i < tend) begin
                game_winner = fw[i];
                game_loser  = fl[i];
                game_over   = fo[i];
            end else begin
                game_winner = 1'b0;
                game_loser  = 1'b0;
                game_over   = 1'b0;
            end
            cmd_valid = hold_v ? 1'b1 : 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_load  = 1'($urandom);
            cmd_init  = 4'($urandom);
            cmd_len   = 8'($urandom);
            #1;
            if (i < tend) begin
                chk("game_en",   32'(game_en), 32'(en_exp[i]));
                chk("init_load", 32'(game_init_load), 32'(ld && i == 0));
                chk("game_ctrl", 32'(game_ctrl), 32'(op));
                chk("busy",      32'(busy), 1);
                chk("cmd_ready_busy", 32'(cmd_ready), 0);
                chk("rsp_valid_early", 32'(rsp_valid), 0);
                if (ld && i == 0) chk("init_val", 32'(game_init_val), 32'(init));
            end else begin
                chk("rsp_valid", 32'(rsp_valid), 1);
                chk("rsp_winners", 32'(rsp_winners), ew);
                chk("rsp_losers",  32'(rsp_losers), el);
                chk("rsp_cycles",  32'(rsp_cycles), ec);
                chk("rsp_over",    32'(rsp_over), 32'(eo));
                chk("resp_ctrl",   32'(game_ctrl), 0);
                chk("resp_en",     32'(game_en), 0);
            end
        end
        repeat (bp) begin
            @(negedge clk);
            #1;
            chk("bp_valid",   32'(rsp_valid), 1);
            chk("bp_winners", 32'(rsp_winners), ew);
            chk("bp_losers",  32'(rsp_losers), el);
            chk("bp_cycles",  32'(rsp_cycles), ec);
            chk("bp_over",    32'(rsp_over), 32'(eo));
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", 32'(rsp_valid), 0);
        chk("post_busy",      32'(busy), 0);
        chk("post_cmd_ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_load = 1'b0; cmd_init = 4'h0; cmd_len = 8'h00;
        game_winner = 1'b0; game_loser = 1'b0; game_over = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_en",        32'(game_en), 0);
        chk("rst_load",      32'(game_init_load), 0);
        chk("rst_ctrl",      32'(game_ctrl), 0);
        chk("rst_val",       32'(game_init_val), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_w",     32'(rsp_winners), 0);
        chk("rst_rsp_l",     32'(rsp_losers), 0);
        chk("rst_rsp_c",     32'(rsp_cycles), 0);
        chk("rst_rsp_o",     32'(rsp_over), 0);
        rst = 1'b0;

        // Load then count up with one winner pulse mid-run
        clr_flags(); fw[2] = 1'b1;
        run_cmd(2'b00, 1'b1, 4'hC, 8'd3, 0, 1'b0);

        // Count down; loser pulse lands in the drain cycle
        clr_flags(); fl[3] = 1'b1;
        run_cmd(2'b11, 1'b1, 4'h3, 8'd2, 0, 1'b0);

        // Game over mid-run, with a winner in the same cycle
        clr_flags(); fw[6] = 1'b1;
        for (int i = 6; i < C_N; i++) fo[i] = 1'b1;
        run_cmd(2'b00, 1'b1, 4'hF, 8'd20, 0, 1'b0);

        // Response back-pressure with cmd_valid held high
        clr_flags(); fw[1] = 1'b1; fl[2] = 1'b1;
        run_cmd(2'b01, 1'b0, 4'h0, 8'd4, 10, 1'b1);

        // Zero length, no load
        clr_flags(); fw[0] = 1'b1;
        run_cmd(2'b10, 1'b0, 4'h5, 8'd0, 0, 1'b0);

        // Game over already present at accept with a load
        clr_flags(); fo[0] = 1'b1; fo[1] = 1'b1;
        run_cmd(2'b01, 1'b1, 4'h7, 8'd5, 2, 1'b0);

        // Reset in the middle of a run aborts without a response
        clr_flags();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_load = 1'b0; cmd_len = 8'd10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("t1_running_en", 32'(game_en), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t1_busy",      32'(busy), 0);
        chk("t1_cmd_ready", 32'(cmd_ready), 1);
        chk("t1_en",        32'(game_en), 0);
        chk("t1_rsp_valid", 32'(rsp_valid), 0);
        chk("t1_rsp_cycles", 32'(rsp_cycles), 0);
        @(negedge clk);
        chk("t1_no_rsp", 32'(rsp_valid), 0);

        // Randomized commands, high winner rate exercises saturation
        for (int k = 0; k < 30; k++) begin
            rnd_flags(int'($urandom_range(60)), int'($urandom_range(60)), int'($urandom_range(4)));
            run_cmd(2'($urandom), 1'($urandom), 4'($urandom), 8'($urandom_range(60)),
                    int'($urandom_range(3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
